// File: rtl/cbus_mem_responder_pkg.sv
// Shared cache-bus types: request/response beats, length/size/burst encodings
// and the responder state enum.
package cbus_mem_responder_pkg;

  // Burst length encodes beats-1.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    strobe_t     strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } cbus_rsp_state_t;

endpackage

// File: rtl/cbus_mem_responder_if.sv
// Cache-bus request/response bundle between an initiator and the memory responder.
interface cbus_mem_responder_if;
  import cbus_mem_responder_pkg::*;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_mem_responder_ram.sv
// Single-port byte-writable RAM; zero read latency gives a combinational read.
module RAM_SinglePort #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic                             clk,
  input  logic                             en,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] strobe,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata
);
  localparam int unsigned NBYTES = DATA_WIDTH / BYTE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Byte-lane write of the enabled word; contents survive reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (strobe[i]) mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign rdata = mem[addr];
    end else begin : g_reg_read
      // Registered read for builds that map onto synchronous block RAM.
      always_ff @(posedge clk) begin
        if (en) rdata <= mem[addr];
      end
    end
  endgenerate
endmodule

// File: rtl/cbus_mem_responder.sv
// Cache-bus memory responder: accepts a request, waits LATENCY cycles, then
// streams one beat per cycle from/to a word-addressed 64-bit memory.
module cbus_mem_responder
  import cbus_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  cbus_mem_responder_if.slave   bus,
  output logic                  busy
);
  cbus_rsp_state_t         state, state_next;
  logic                    is_write_q;
  axi_burst_t              burst_q;
  logic [ADDR_WIDTH-1:0]   index;
  logic [3:0]              beats_left;
  logic [3:0]              wait_cnt;
  logic                    beat;
  logic                    ram_en;
  strobe_t                 ram_strobe;
  logic [63:0]             ram_rdata;

  // Request fields the responder never looks at (size, aliased/low address bits).
  logic unused_req_bits;
  assign unused_req_bits = ^{bus.creq.size, bus.creq.addr[63:ADDR_WIDTH+3], bus.creq.addr[2:0]};

  assign beat = (state == BURST) && bus.creq.valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: a dropped valid aborts from WAIT/BURST; last beat returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.creq.valid) state_next = (LATENCY == 0) ? BURST : WAIT;
      WAIT:  if (!bus.creq.valid) state_next = IDLE;
             else if (wait_cnt == 4'd1) state_next = BURST;
      BURST: if (!bus.creq.valid || beats_left == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, latency countdown and per-beat address/count advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_write_q <= 1'b0;
      burst_q    <= AXI_BURST_FIXED;
      index      <= '0;
      beats_left <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.creq.valid) begin
          is_write_q <= bus.creq.is_write;
          burst_q    <= bus.creq.burst;
          index      <= bus.creq.addr[ADDR_WIDTH+2:3];
          beats_left <= bus.creq.len;
          wait_cnt   <= 4'(LATENCY);
        end
        WAIT: if (bus.creq.valid) wait_cnt <= wait_cnt - 4'd1;
        BURST: if (bus.creq.valid) begin
          if (burst_q == AXI_BURST_INCR) index <= index + ADDR_WIDTH'(1);
          beats_left <= beats_left - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: beat handshake, gated read data, RAM enable and write lanes.
  always_comb begin
    bus.cresp  = '0;
    busy       = (state != IDLE);
    ram_en     = beat;
    ram_strobe = (beat && is_write_q) ? bus.creq.strobe : '0;
    if (beat) begin
      bus.cresp.ready = 1'b1;
      bus.cresp.last  = (beats_left == 4'd0);
      if (!is_write_q) bus.cresp.data = ram_rdata;
    end
  end

  RAM_SinglePort #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (64),
    .BYTE_WIDTH   (8),
    .READ_LATENCY (0)
  ) u_ram (
    .clk    (clk),
    .en     (ram_en),
    .addr   (index),
    .strobe (ram_strobe),
    .wdata  (bus.creq.data),
    .rdata  (ram_rdata)
  );
endmodule
